// File: rtl/vocab_pkg.sv
// rtl/vocab_pkg.sv - shared vocabulary types, constants and character extraction
package vocab_pkg;

    localparam int VOCAB_DATA_WIDTH  = 8;
    localparam int VOCAB_WORD_LENGTH = 3;
    localparam int VOCAB_WORD_BITS   = VOCAB_DATA_WIDTH * VOCAB_WORD_LENGTH;

    typedef logic [VOCAB_DATA_WIDTH-1:0] char_t;

    localparam char_t NULL_CHAR = '0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EMIT
    } state_t;

    // Char 0 lives in the MSBs of a packed entry.
    function automatic char_t word_char(input logic [VOCAB_WORD_BITS-1:0] word,
                                        input int unsigned               idx);
        return word[VOCAB_WORD_BITS-1-idx*VOCAB_DATA_WIDTH -: VOCAB_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/vocab_ram.sv
// rtl/vocab_ram.sv - 1W/1R synchronous vocabulary RAM, read-first, no reset
module vocab_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data
);

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Both ports sample mem before the edge updates it, so a same-address
    // collision returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/detokenizer.sv
// rtl/detokenizer.sv - token id to character stream via vocabulary RAM lookup
module detokenizer #(
    parameter int ADDR_WIDTH  = 4,
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] wr_word,
    input  logic                              token_valid,
    output logic                              token_ready,
    input  logic [ADDR_WIDTH-1:0]             token_id,
    output logic                              char_valid,
    input  logic                              char_ready,
    output logic [DATA_WIDTH-1:0]             char_data,
    output logic                              char_last,
    output logic                              nullptr_err
);

    import vocab_pkg::*;

    localparam int WORD_BITS = WORD_LENGTH * DATA_WIDTH;
    localparam int CNT_W     = $clog2(WORD_LENGTH + 1);

    state_t               state;
    logic [WORD_BITS-1:0] rd_word;
    logic [WORD_BITS-1:0] shift_q;
    logic [CNT_W-1:0]     len;
    logic [CNT_W-1:0]     remain;
    logic                 found;
    logic                 accept;

    assign accept = token_valid && token_ready;

    // The RAM latches the address on the accept edge, so its output is
    // valid throughout READ and a same-edge rewrite is not observed.
    vocab_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_word),
        .rd_en   (accept),
        .rd_addr (token_id),
        .rd_data (rd_word)
    );

    // Length is the count of chars before the first NUL, scanning from char 0.
    always_comb begin
        len   = CNT_W'(WORD_LENGTH);
        found = 1'b0;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            if (!found &&
                rd_word[WORD_BITS-1-i*DATA_WIDTH -: DATA_WIDTH] == DATA_WIDTH'(NULL_CHAR)) begin
                len   = CNT_W'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            token_ready <= 1'b1;
            char_valid  <= 1'b0;
            char_last   <= 1'b0;
            char_data   <= '0;
            nullptr_err <= 1'b0;
            shift_q     <= '0;
            remain      <= '0;
        end else begin
            nullptr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        token_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (len == '0) begin
                        nullptr_err <= 1'b1;
                        token_ready <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        char_data  <= rd_word[WORD_BITS-1 -: DATA_WIDTH];
                        shift_q    <= rd_word << DATA_WIDTH;
                        remain     <= len - CNT_W'(1);
                        char_valid <= 1'b1;
                        char_last  <= (len == CNT_W'(1));
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (char_ready) begin
                        if (char_last) begin
                            char_valid  <= 1'b0;
                            char_last   <= 1'b0;
                            token_ready <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            char_data <= shift_q[WORD_BITS-1 -: DATA_WIDTH];
                            shift_q   <= shift_q << DATA_WIDTH;
                            remain    <= remain - CNT_W'(1);
                            char_last <= (remain == CNT_W'(1));
                        end
                    end
                end
                default: begin
                    token_ready <= 1'b1;
                    char_valid  <= 1'b0;
                    char_last   <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
